icache_line_adaptor: RTL and testbench

//  Sits directly downstream of the icache controller, between its line-wide pmem port and burst-based physical memory.

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_beat_buffer.sv | 34 +++
 rtl/icache_line_adaptor.sv | 141 ++++++++++++++
 tb/tb_icache_line_adaptor.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and default geometry for the icache line adaptor.
// Pure declarations: no latency, no flow control.
package icache_pkg;

  localparam int LINE_W_DFLT  = 256;
  localparam int BURST_W_DFLT = 64;
  localparam int ADDR_W_DFLT  = 32;

  // Beat counter must be at least one bit even for a single-beat line.
  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  localparam int BEATS = LINE_W_DFLT / BURST_W_DFLT;
  localparam int CNT_W = cnt_width(BEATS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

endpackage

// File: rtl/icache_beat_buffer.sv
// Line-wide buffer: parallel line load, indexed beat write, indexed beat read.
// Writes land on the next clock; the beat read is combinational; no backpressure.
module icache_beat_buffer #(
  parameter int LINE_W  = 256,
  parameter int BURST_W = 64,
  parameter int IDX_W   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [LINE_W-1:0]  load_dat_i,
  input  logic               wr_i,
  input  logic [IDX_W-1:0]   idx_i,
  input  logic [BURST_W-1:0] wr_dat_i,
  output logic [LINE_W-1:0]  line_o,
  output logic [BURST_W-1:0] beat_o
);

  logic [LINE_W-1:0] line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= load_dat_i;
    end else if (wr_i) begin
      line_q[idx_i*BURST_W +: BURST_W] <= wr_dat_i;
    end
  end

  assign line_o = line_q;
  assign beat_o = line_q[idx_i*BURST_W +: BURST_W];

endmodule

// File: rtl/icache_line_adaptor.sv
// Converts cache line reads/writes into BEATS memory beats; request->mem op 1 cycle, last beat->line_resp_o 1 cycle.
// Memory paces each beat with mem_resp_i (gaps allowed); optional perf counters under ICACHE_ADAPTOR_PERF_CNT_EN.
module icache_line_adaptor
  import icache_pkg::*;
#(
  parameter int LINE_W  = LINE_W_DFLT,
  parameter int BURST_W = BURST_W_DFLT,
  parameter int ADDR_W  = ADDR_W_DFLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDR_W-1:0]  line_addr_i,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [LINE_W-1:0]  line_wdata_i,
  output logic [LINE_W-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic [ADDR_W-1:0]  mem_addr_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic [BURST_W-1:0] mem_wdata_o,
  input  logic [BURST_W-1:0] mem_rdata_i,
  input  logic               mem_resp_i
`ifdef ICACHE_ADAPTOR_PERF_CNT_EN
  ,
  output logic [31:0]        perf_rd_lines_o,
  output logic [31:0]        perf_wr_lines_o,
  output logic [31:0]        perf_busy_cycles_o
`endif
);

  localparam int NBEATS = LINE_W / BURST_W;
  localparam int NCNT_W = cnt_width(NBEATS);
  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam logic [NCNT_W-1:0] LAST_IDX = NCNT_W'(NBEATS - 1);

  adaptor_state_t      state_q, state_d;
  logic [NCNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                buf_load, buf_wr;
  logic                last_beat;
  logic [LINE_W-1:0]   buf_line;
  logic [BURST_W-1:0]  buf_beat;

  assign last_beat = (cnt_q == LAST_IDX);

  icache_beat_buffer #(
    .LINE_W  (LINE_W),
    .BURST_W (BURST_W),
    .IDX_W   (NCNT_W)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (buf_load),
    .load_dat_i (line_wdata_i),
    .wr_i       (buf_wr),
    .idx_i      (cnt_q),
    .wr_dat_i   (mem_rdata_i),
    .line_o     (buf_line),
    .beat_o     (buf_beat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    buf_load = 1'b0;
    buf_wr   = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_write_i || line_read_i) begin
          addr_d   = {line_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          cnt_d    = '0;
          buf_load = line_write_i;
          state_d  = line_write_i ? WRITE : READ;
        end
      end
      READ: begin
        if (mem_resp_i) begin
          buf_wr = 1'b1;
          cnt_d  = last_beat ? '0 : cnt_q + NCNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      WRITE: begin
        if (mem_resp_i) begin
          cnt_d = last_beat ? '0 : cnt_q + NCNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      // The cache still holds its request here; ignoring it prevents a retrigger.
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_read_o   = (state_q == READ);
    mem_write_o  = (state_q == WRITE);
    line_resp_o  = (state_q == DONE);
    mem_addr_o   = addr_q;
    mem_wdata_o  = (state_q == WRITE) ? buf_beat : '0;
    line_rdata_o = buf_line;
  end

`ifdef ICACHE_ADAPTOR_PERF_CNT_EN
  logic        op_wr_q;
  logic [31:0] rd_lines_q, wr_lines_q, busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_wr_q    <= 1'b0;
      rd_lines_q <= '0;
      wr_lines_q <= '0;
      busy_q     <= '0;
    end else begin
      if (state_q == IDLE && (line_write_i || line_read_i)) op_wr_q <= line_write_i;
      if (state_q == DONE && !op_wr_q && rd_lines_q != '1) rd_lines_q <= rd_lines_q + 32'd1;
      if (state_q == DONE && op_wr_q && wr_lines_q != '1) wr_lines_q <= wr_lines_q + 32'd1;
      if ((state_q == READ || state_q == WRITE) && busy_q != '1) busy_q <= busy_q + 32'd1;
    end
  end

  assign perf_rd_lines_o    = rd_lines_q;
  assign perf_wr_lines_o    = wr_lines_q;
  assign perf_busy_cycles_o = busy_q;
`endif

endmodule

// File: tb/tb_icache_line_adaptor.sv
// Directed bench for icache_line_adaptor: vector table of line transfers plus hand-written corner sequences.
module tb_icache_line_adaptor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  line_addr_i;
  logic         line_read_i;
  logic         line_write_i;
  logic [255:0] line_wdata_i;
  logic [255:0] line_rdata_o;
  logic         line_resp_o;
  logic [31:0]  mem_addr_o;
  logic         mem_read_o;
  logic         mem_write_o;
  logic [63:0]  mem_wdata_o;
  logic [63:0]  mem_rdata_i;
  logic         mem_resp_i;
`ifdef ICACHE_ADAPTOR_PERF_CNT_EN
  logic [31:0]  perf_rd_lines_o, perf_wr_lines_o, perf_busy_cycles_o;
`endif

  int nchk = 0;
  int nerr = 0;
  int resp_pulses = 0;

  always #5 clk = ~clk;

  icache_line_adaptor dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .line_addr_i  (line_addr_i),
    .line_read_i  (line_read_i),
    .line_write_i (line_write_i),
    .line_wdata_i (line_wdata_i),
    .line_rdata_o (line_rdata_o),
    .line_resp_o  (line_resp_o),
    .mem_addr_o   (mem_addr_o),
    .mem_read_o   (mem_read_o),
    .mem_write_o  (mem_write_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i),
    .mem_resp_i   (mem_resp_i)
`ifdef ICACHE_ADAPTOR_PERF_CNT_EN
    ,
    .perf_rd_lines_o    (perf_rd_lines_o),
    .perf_wr_lines_o    (perf_wr_lines_o),
    .perf_busy_cycles_o (perf_busy_cycles_o)
`endif
  );

  always @(negedge clk) if (line_resp_o) resp_pulses++;

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [31:0]  exp_addr;
    int           g0, g1, g2, g3;
  } vec_t;

  vec_t vecs[4];

  localparam logic [255:0] LINE_R0 = {64'h4444444444444444, 64'h3333333333333333,
                                      64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] LINE_W0 = 256'h0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_89ABCDEF0123CDEF;
  localparam logic [255:0] LINE_R1 = 256'hDEADBEEF00000001_CAFEF00D00000002_0BADC0DE00000003_FEEDFACE00000004;
  localparam logic [255:0] LINE_W1 = 256'hA5A5A5A5A5A5A5A5_5A5A5A5A5A5A5A5A_0000FFFF0000FFFF_FFFF0000FFFF0000;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input bit wr, input bit rd, input logic [31:0] addr, input logic [255:0] wdata);
    line_addr_i  = addr;
    line_wdata_i = wdata;
    line_write_i = wr;
    line_read_i  = rd;
    step();
  endtask

  // Entered one cycle after the request; returns in the cycle where line_resp_o must be high.
  task automatic burst(input bit wr, input logic [255:0] data, input int g0, input int g1, input int g2, input int g3);
    int gaps[4];
    gaps = '{g0, g1, g2, g3};
    for (int k = 0; k < 4; k++) begin
      for (int g = 0; g < gaps[k]; g++) begin
        chk(wr ? "mem_write_gap" : "mem_read_gap", {255'd0, wr ? mem_write_o : mem_read_o}, 256'd1);
        if (wr) chk("wdata_gap", {192'd0, mem_wdata_o}, {192'd0, data[k*64 +: 64]});
        step();
      end
      if (wr) chk("wdata_beat", {192'd0, mem_wdata_o}, {192'd0, data[k*64 +: 64]});
      mem_resp_i  = 1'b1;
      mem_rdata_i = wr ? 64'hBAD0BAD0BAD0BAD0 : data[k*64 +: 64];
      step();
      mem_resp_i  = 1'b0;
      mem_rdata_i = '0;
      chk("line_resp_beat", {255'd0, line_resp_o}, (k == 3) ? 256'd1 : 256'd0);
    end
    if (!wr) chk("line_rdata", line_rdata_o, data);
  endtask

  task automatic xfer(input vec_t v);
    start(v.wr, !v.wr, v.addr, v.data);
    chk("mem_read_lat", {255'd0, mem_read_o}, v.wr ? 256'd0 : 256'd1);
    chk("mem_write_lat", {255'd0, mem_write_o}, v.wr ? 256'd1 : 256'd0);
    chk("mem_addr", {224'd0, mem_addr_o}, {224'd0, v.exp_addr});
    burst(v.wr, v.data, v.g0, v.g1, v.g2, v.g3);
    line_read_i  = 1'b0;
    line_write_i = 1'b0;
    step();
    chk("idle_after_done", {254'd0, line_resp_o, mem_read_o | mem_write_o}, 256'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    vecs[0] = '{wr: 1'b0, addr: 32'h8000_1234, data: LINE_R0, exp_addr: 32'h8000_1220, g0: 0, g1: 0, g2: 0, g3: 0};
    vecs[1] = '{wr: 1'b1, addr: 32'h0000_0040, data: LINE_W0, exp_addr: 32'h0000_0040, g0: 0, g1: 0, g2: 2, g3: 5};
    vecs[2] = '{wr: 1'b0, addr: 32'hFFFF_FFFF, data: LINE_R1, exp_addr: 32'hFFFF_FFE0, g0: 1, g1: 0, g2: 3, g3: 0};
    vecs[3] = '{wr: 1'b1, addr: 32'h0000_001F, data: LINE_W1, exp_addr: 32'h0000_0000, g0: 2, g1: 1, g2: 0, g3: 1};

    rst_n = 1'b0;
    line_addr_i = '0; line_read_i = 1'b0; line_write_i = 1'b0; line_wdata_i = '0;
    mem_rdata_i = '0; mem_resp_i = 1'b0;
    step();
    step();
    chk("rst_outputs", {line_resp_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o}, '0);
    chk("rst_rdata", line_rdata_o, '0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 4; i++) xfer(vecs[i]);

    // Stray memory responses while idle must not move anything.
    mem_resp_i = 1'b1;
    step();
    step();
    mem_resp_i = 1'b0;
    chk("idle_resp_ignored", {254'd0, line_resp_o, mem_read_o | mem_write_o}, 256'd0);

    // Writeback and read requested together: write first, one idle cycle, then the read.
    p0 = resp_pulses;
    start(1'b1, 1'b1, 32'h1234_5678, LINE_W0);
    chk("wb_first_write", {254'd0, mem_write_o, mem_read_o}, 256'd2);
    chk("wb_addr", {224'd0, mem_addr_o}, {224'd0, 32'h1234_5660});
    burst(1'b1, LINE_W0, 0, 0, 0, 0);
    line_write_i = 1'b0;
    step();
    chk("wb_idle_gap", {254'd0, line_resp_o, mem_read_o}, 256'd0);
    step();
    chk("wb_then_read", {254'd0, mem_read_o, mem_write_o}, 256'd2);
    burst(1'b0, LINE_R1, 0, 1, 0, 0);
    line_read_i = 1'b0;
    step();
    step();
    chk("wb_resp_pulses", 256'(resp_pulses - p0), 256'd2);

    // Reset in the middle of a read discards the partial line.
    start(1'b0, 1'b1, 32'h0000_0100, '0);
    for (int k = 0; k < 2; k++) begin
      mem_resp_i = 1'b1;
      mem_rdata_i = LINE_R0[k*64 +: 64];
      step();
    end
    mem_resp_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", {line_resp_o, mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o}, '0);
    chk("midrst_rdata", line_rdata_o, '0);
    line_read_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    xfer('{wr: 1'b0, addr: 32'h0000_0100, data: LINE_R1, exp_addr: 32'h0000_0100, g0: 0, g1: 0, g2: 0, g3: 0});

`ifdef ICACHE_ADAPTOR_PERF_CNT_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("perf_rst", {perf_rd_lines_o, perf_wr_lines_o, perf_busy_cycles_o}, '0);
    for (int i = 0; i < 5; i++) begin
      vec_t v;
      v = '{wr: (i % 2 == 1), addr: 32'(i * 64), data: LINE_R0, exp_addr: 32'(i * 64), g0: 0, g1: 0, g2: 0, g3: 0};
      xfer(v);
    end
    chk("perf_rd_lines", {224'd0, perf_rd_lines_o}, 256'd3);
    chk("perf_wr_lines", {224'd0, perf_wr_lines_o}, 256'd2);
    chk("perf_busy", {224'd0, perf_busy_cycles_o}, 256'd20);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
